// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial adder controller and its slice.
package nibble_serial_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NIB_W = 4;

    // Width of the nibble index; at least one bit so the counter always exists.
    function automatic int idx_width(input int width);
        return (width / NIB_W > 1) ? $clog2(width / NIB_W) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla4_slice.sv
// 4-bit combinational carry-lookahead slice with group generate/propagate.
module cla4_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout,
    output logic       o_gout,
    output logic       o_pout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = o_gout | (o_pout & i_cin);

    assign o_gout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_pout = &w_p;
    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add sequenced one nibble per clock through a single lookahead slice.
// Define NIBBLE_SERIAL_SUB_EN to enable subtraction through the sub input.
module nibble_serial_adder_ctrl
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             pout
);
    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(WIDTH);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t                     r_state, w_next;
    logic [NIB-1:0][NIB_W-1:0]  r_a, r_b, r_sum;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_carry, r_pacc, r_cout, r_pout;
    logic [NIB_W-1:0]           w_a_nib, w_b_nib, w_s_nib;
    logic                       w_co, w_po, w_g_unused, w_cin0, w_last;

    assign w_a_nib = r_a[r_idx];
    assign w_last  = (r_idx == IDX_W'(NIB - 1));

`ifdef NIBBLE_SERIAL_SUB_EN
    logic r_sub;
    always_ff @(posedge clk) begin
        if (rst)                             r_sub <= 1'b0;
        else if (r_state == IDLE && start)   r_sub <= sub;
    end
    assign w_b_nib = r_sub ? ~r_b[r_idx] : r_b[r_idx];
    assign w_cin0  = sub ? 1'b1 : cin;
`else
    logic w_sub_unused;
    assign w_sub_unused = sub;
    assign w_b_nib      = r_b[r_idx];
    assign w_cin0       = cin;
`endif

    cla4_slice u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_s_nib),
        .o_cout (w_co),
        .o_gout (w_g_unused),
        .o_pout (w_po)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Unwritten sum nibbles keep their old contents until overwritten in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_pacc  <= 1'b0;
            r_cout  <= 1'b0;
            r_pout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_idx   <= '0;
                    r_carry <= w_cin0;
                    r_pacc  <= 1'b1;
                end
                RUN: begin
                    r_sum[r_idx] <= w_s_nib;
                    r_carry      <= w_co;
                    r_pacc       <= r_pacc & w_po;
                    if (w_last) begin
                        r_cout <= w_co;
                        r_pout <= r_pacc & w_po;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign done  = (r_state == DONE);
    assign sum   = r_sum;
    assign cout  = r_cout;
    assign pout  = r_pout;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: expected results queued at accept, checked by a done monitor.
module tb_nibble_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0;
    logic        ready, done, cout, pout;
    logic [15:0] sum;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        pout;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0, n_done = 0;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .ready(ready), .done(done), .sum(sum), .cout(cout), .pout(pout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("pout", 32'(pout), 32'(e.pout));
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (done !== 1'b1 && n < 20);
    endtask

    task automatic accept(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          input logic ts, input exp_t e, input bit push);
        chk("ready_before_start", 32'(ready), 32'd1);
        a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
        @(posedge clk);
        if (push) sb.push_back(e);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          input logic ts, input logic [15:0] es, input logic ec, input logic ep);
        int n;
        accept(ta, tb_v, tc, ts, '{sum: es, cout: ec, pout: ep}, 1'b1);
        wait_done(n);
        chk("latency", 32'(n), 32'd4);
        @(posedge clk); #1;
        chk("ready_after_done", 32'(ready), 32'd1);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin : stim
        int n, d0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_pout", 32'(pout), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op(16'h8000, 16'h8001, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0);

        // second start during RUN must be dropped
        d0 = n_done;
        accept(16'h00FF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h0100, cout: 1'b0, pout: 1'b0}, 1'b1);
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h1111; start = 1'b1;
        chk("ready_in_run", 32'(ready), 32'd0);
        @(posedge clk); #1 start = 1'b0;
        wait_done(n);
        chk("latency_ignored", 32'(n), 32'd2);
        repeat (10) @(posedge clk);
        #1;
        chk("single_done", 32'(n_done - d0), 32'd1);

        // abort mid-RUN after a result with nonzero sum and cout
        run_op(16'h8000, 16'h8001, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0);
        d0 = n_done;
        accept(16'h1234, 16'h1111, 1'b0, 1'b0, '{sum: 16'h0, cout: 1'b0, pout: 1'b0}, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_pout", 32'(pout), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(n_done - d0), 32'd0);

        // rst and start on the same edge: reset wins
        d0 = n_done;
        a = 16'h0101; b = 16'h0202; start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        chk("rst_start_ready", 32'(ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("rst_start_no_done", 32'(n_done - d0), 32'd0);

`ifdef NIBBLE_SERIAL_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
`else
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
